// File: rtl/bus_demux_1to4_if.sv
// Request/response bus between the core load/store port, the router and the
// four memory-mapped targets. The router takes the slave modport; whatever
// models the core and the targets takes the master modport.
interface bus_demux_1to4_if;
   // core side
   logic         req_valid;
   logic         req_ready;
   logic [31:0]  req_addr;
   logic [31:0]  req_wdata;
   logic         req_we;
   logic [3:0]   req_be;
   logic         rsp_valid;
   logic [31:0]  rsp_rdata;
   logic         rsp_err;
   // target side
   logic [3:0]   tgt_valid;
   logic [3:0]   tgt_ready;
   logic [31:0]  tgt_addr;
   logic [31:0]  tgt_wdata;
   logic         tgt_we;
   logic [3:0]   tgt_be;
   logic [3:0]   tgt_rsp_valid;
   logic [127:0] tgt_rdata;

   modport slave (
      input  req_valid, req_addr, req_wdata, req_we, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output tgt_valid, tgt_addr, tgt_wdata, tgt_we, tgt_be,
      input  tgt_ready, tgt_rsp_valid, tgt_rdata
   );

   modport master (
      output req_valid, req_addr, req_wdata, req_we, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  tgt_valid, tgt_addr, tgt_wdata, tgt_we, tgt_be,
      output tgt_ready, tgt_rsp_valid, tgt_rdata
   );
endinterface

// File: rtl/bus_demux_1to4.sv
// Data-bus request router: accepts one core request at a time, steers it to
// one of four targets selected by req_addr[SEL_MSB:SEL_MSB-1], waits for the
// target response (bounded by TIMEOUT cycles, 0 = unbounded) and returns a
// one-cycle response pulse with read data and a timeout error flag.
module bus_demux_1to4 #(
   parameter int unsigned SEL_MSB = 31,
   parameter int unsigned TIMEOUT = 255
) (
   input logic            clk,
   input logic            rst_n,
   bus_demux_1to4_if.slave bus
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t      state;
   logic [1:0]  sel;
   logic [15:0] cnt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        sel_ready;
   logic        sel_rsp;
   logic [31:0] sel_rdata;
   logic        timeout_hit;

   // Only the selected target's handshake and data are ever looked at.
   assign sel_ready   = bus.tgt_ready[sel];
   assign sel_rsp     = bus.tgt_rsp_valid[sel];
   assign sel_rdata   = bus.tgt_rdata[{sel, 5'd0} +: 32];
   assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

   // Handshake outputs are pure decodes of the state register.
   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.tgt_valid = (state == REQ) ? (4'b0001 << sel) : 4'b0000;

   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.tgt_addr  = addr_q;
   assign bus.tgt_wdata = wdata_q;
   assign bus.tgt_we    = we_q;
   assign bus.tgt_be    = be_q;

   // Transaction FSM: latch request, drive target, collect response or time out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sel     <= '0;
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  addr_q  <= bus.req_addr;
                  wdata_q <= bus.req_wdata;
                  we_q    <= bus.req_we;
                  be_q    <= bus.req_be;
                  sel     <= bus.req_addr[SEL_MSB -: 2];
                  cnt     <= '0;
                  state   <= REQ;
               end
            end
            REQ: begin
               cnt <= cnt + 16'd1;
               if (sel_ready && sel_rsp) begin
                  rdata_q <= we_q ? '0 : sel_rdata;
                  err_q   <= 1'b0;
                  state   <= RESP;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state   <= RESP;
               end else if (sel_ready) begin
                  state   <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt + 16'd1;
               if (sel_rsp) begin
                  rdata_q <= we_q ? '0 : sel_rdata;
                  err_q   <= 1'b0;
                  state   <= RESP;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state   <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_demux_1to4.sv
// Directed bench for bus_demux_1to4 (TIMEOUT = 8): load, store, back-pressure,
// timeout, crosstalk between targets and reset in the middle of a transaction.
module tb_bus_demux_1to4;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   bus_demux_1to4_if bif ();

   bus_demux_1to4 #(.SEL_MSB(31), .TIMEOUT(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, 32'(bif.req_ready), 32'h1);
      chk({tag, "_rsp_valid"}, 32'(bif.rsp_valid), 32'h0);
      chk({tag, "_rsp_rdata"}, bif.rsp_rdata, 32'h0);
      chk({tag, "_rsp_err"},   32'(bif.rsp_err), 32'h0);
      chk({tag, "_tgt_valid"}, 32'(bif.tgt_valid), 32'h0);
      chk({tag, "_tgt_addr"},  bif.tgt_addr, 32'h0);
      chk({tag, "_tgt_wdata"}, bif.tgt_wdata, 32'h0);
      chk({tag, "_tgt_we"},    32'(bif.tgt_we), 32'h0);
      chk({tag, "_tgt_be"},    32'(bif.tgt_be), 32'h0);
   endtask

   task automatic idle_inputs();
      bif.req_valid     = 1'b0;
      bif.tgt_ready     = 4'b0000;
      bif.tgt_rsp_valid = 4'b0000;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [3:0] be);
      bif.req_valid = 1'b1;
      bif.req_addr  = a;
      bif.req_wdata = d;
      bif.req_we    = we;
      bif.req_be    = be;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bif.req_valid     = 1'b0;
      bif.req_addr      = '0;
      bif.req_wdata     = '0;
      bif.req_we        = 1'b0;
      bif.req_be        = '0;
      bif.tgt_ready     = '0;
      bif.tgt_rsp_valid = '0;
      bif.tgt_rdata     = '0;

      // reset state
      #3;
      chk_reset_vals("rst");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // load to T2, ready in first REQ cycle, response one cycle later
      issue(32'h8000_0010, 32'h1111_1111, 1'b0, 4'hF);
      tick();
      chk("ld_tgt_valid", 32'(bif.tgt_valid), 32'h4);
      chk("ld_req_ready", 32'(bif.req_ready), 32'h0);
      chk("ld_tgt_addr",  bif.tgt_addr, 32'h8000_0010);
      chk("ld_tgt_we",    32'(bif.tgt_we), 32'h0);
      idle_inputs();
      bif.tgt_ready = 4'b0100;
      tick();
      chk("ld_wait_tgt_valid", 32'(bif.tgt_valid), 32'h0);
      chk("ld_wait_rsp_valid", 32'(bif.rsp_valid), 32'h0);
      bif.tgt_ready         = 4'b0000;
      bif.tgt_rsp_valid     = 4'b0100;
      bif.tgt_rdata[95:64]  = 32'hDEAD_BEEF;
      tick();
      chk("ld_rsp_valid", 32'(bif.rsp_valid), 32'h1);
      chk("ld_rsp_rdata", bif.rsp_rdata, 32'hDEAD_BEEF);
      chk("ld_rsp_err",   32'(bif.rsp_err), 32'h0);
      idle_inputs();
      tick();
      chk("ld_after_rsp_valid", 32'(bif.rsp_valid), 32'h0);
      chk("ld_after_req_ready", 32'(bif.req_ready), 32'h1);

      // store to T0, ready and response in the same cycle
      issue(32'h0000_0004, 32'h1234_5678, 1'b1, 4'b0011);
      tick();
      chk("st_tgt_valid", 32'(bif.tgt_valid), 32'h1);
      chk("st_tgt_addr",  bif.tgt_addr, 32'h0000_0004);
      chk("st_tgt_wdata", bif.tgt_wdata, 32'h1234_5678);
      chk("st_tgt_be",    32'(bif.tgt_be), 32'h3);
      chk("st_tgt_we",    32'(bif.tgt_we), 32'h1);
      idle_inputs();
      bif.tgt_ready        = 4'b0001;
      bif.tgt_rsp_valid    = 4'b0001;
      bif.tgt_rdata[31:0]  = 32'hCAFE_F00D;
      tick();
      chk("st_rsp_valid", 32'(bif.rsp_valid), 32'h1);
      chk("st_rsp_rdata", bif.rsp_rdata, 32'h0);
      chk("st_rsp_err",   32'(bif.rsp_err), 32'h0);
      idle_inputs();
      tick();
      chk("st_after_req_ready", 32'(bif.req_ready), 32'h1);

      // back-pressure on T1 for 5 cycles, other targets ready (ignored)
      issue(32'h4000_0020, 32'hA5A5_A5A5, 1'b1, 4'hF);
      tick();
      idle_inputs();
      bif.req_addr      = 32'hFFFF_FFFF;
      bif.req_wdata     = 32'h0;
      bif.req_be        = 4'h0;
      bif.tgt_ready     = 4'b1101;
      bif.tgt_rsp_valid = 4'b1101;
      for (int i = 0; i < 5; i++) begin
         chk("bp_tgt_valid", 32'(bif.tgt_valid), 32'h2);
         chk("bp_req_ready", 32'(bif.req_ready), 32'h0);
         chk("bp_tgt_addr",  bif.tgt_addr, 32'h4000_0020);
         chk("bp_tgt_wdata", bif.tgt_wdata, 32'hA5A5_A5A5);
         chk("bp_rsp_valid", 32'(bif.rsp_valid), 32'h0);
         tick();
      end
      chk("bp_still_valid", 32'(bif.tgt_valid), 32'h2);
      bif.tgt_ready         = 4'b0010;
      bif.tgt_rsp_valid     = 4'b0010;
      bif.tgt_rdata[63:32]  = 32'h5555_5555;
      tick();
      chk("bp_rsp_valid_end", 32'(bif.rsp_valid), 32'h1);
      chk("bp_rsp_rdata",     bif.rsp_rdata, 32'h0);
      chk("bp_rsp_err",       32'(bif.rsp_err), 32'h0);
      idle_inputs();
      tick();

      // timeout on T3: never ready, other targets chatter
      issue(32'hC000_0000, 32'h0, 1'b0, 4'hF);
      tick();
      idle_inputs();
      bif.tgt_ready     = 4'b0111;
      bif.tgt_rsp_valid = 4'b0111;
      for (int i = 0; i < 8; i++) begin
         chk("to_tgt_valid", 32'(bif.tgt_valid), 32'h8);
         chk("to_rsp_valid", 32'(bif.rsp_valid), 32'h0);
         tick();
      end
      chk("to_rsp_valid_end", 32'(bif.rsp_valid), 32'h1);
      chk("to_rsp_err",       32'(bif.rsp_err), 32'h1);
      chk("to_rsp_rdata",     bif.rsp_rdata, 32'h0);
      chk("to_tgt_valid_end", 32'(bif.tgt_valid), 32'h0);
      idle_inputs();
      tick();
      chk("to_after_req_ready", 32'(bif.req_ready), 32'h1);

      // crosstalk: T0 responds while T1 is pending
      issue(32'h4000_0000, 32'h0, 1'b0, 4'hF);
      tick();
      chk("xt_tgt_valid", 32'(bif.tgt_valid), 32'h2);
      idle_inputs();
      bif.tgt_ready = 4'b0010;
      tick();
      bif.tgt_ready        = 4'b0000;
      bif.tgt_rsp_valid    = 4'b0001;
      bif.tgt_rdata[31:0]  = 32'hFFFF_FFFF;
      tick();
      chk("xt_ignored_rsp_valid", 32'(bif.rsp_valid), 32'h0);
      bif.tgt_rsp_valid    = 4'b0011;
      bif.tgt_rdata[63:32] = 32'h0000_00AA;
      tick();
      chk("xt_rsp_valid", 32'(bif.rsp_valid), 32'h1);
      chk("xt_rsp_rdata", bif.rsp_rdata, 32'h0000_00AA);
      chk("xt_rsp_err",   32'(bif.rsp_err), 32'h0);
      idle_inputs();
      tick();

      // reset while in WAIT
      issue(32'h8000_0040, 32'hBEEF_0001, 1'b0, 4'b1010);
      tick();
      idle_inputs();
      bif.tgt_ready = 4'b0100;
      tick();
      chk("rw_wait_tgt_valid", 32'(bif.tgt_valid), 32'h0);
      chk("rw_wait_tgt_addr",  bif.tgt_addr, 32'h8000_0040);
      bif.tgt_ready = 4'b0000;
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rw_async");
      bif.tgt_rsp_valid    = 4'b0100;
      bif.tgt_rdata[95:64] = 32'h0BAD_0BAD;
      tick();
      tick();
      rst_n = 1'b1;
      idle_inputs();
      tick();
      chk("rw_post_rsp_valid", 32'(bif.rsp_valid), 32'h0);
      chk("rw_post_req_ready", 32'(bif.req_ready), 32'h1);
      issue(32'h0000_0100, 32'h0, 1'b0, 4'hF);
      tick();
      chk("rw_new_tgt_valid", 32'(bif.tgt_valid), 32'h1);
      idle_inputs();
      bif.tgt_ready        = 4'b0001;
      bif.tgt_rsp_valid    = 4'b0001;
      bif.tgt_rdata[31:0]  = 32'h0123_4567;
      tick();
      chk("rw_new_rsp_valid", 32'(bif.rsp_valid), 32'h1);
      chk("rw_new_rsp_rdata", bif.rsp_rdata, 32'h0123_4567);
      chk("rw_new_rsp_err",   32'(bif.rsp_err), 32'h0);
      idle_inputs();
      tick();
      chk("rw_end_rsp_valid", 32'(bif.rsp_valid), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
